// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS test controller: FSM state encoding and
// default sizing of the reset hold and cycle/timeout counters.
package prbs_pkg;

  localparam int unsigned RST_CYCLES_DEF = 2;
  localparam int unsigned TO_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESET_DP = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/prbs_test_ctrl.sv
// Sequences one PRBS pattern-detection run: resets the datapath, counts RUN
// cycles until detection, timeout or abort, and reports a held pass/fail.
module prbs_test_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned TO_W       = TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     cfg_pattern,
  input  logic [3:0]      cfg_n,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            dp_detected,
  output logic            dp_rst,
  output logic [31:0]     dp_pattern,
  output logic [3:0]      dp_n,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [TO_W-1:0] cycle_cnt
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  state_e          state_q;
  logic [3:0]      rst_cnt_q;
  logic [TO_W-1:0] timeout_q;
  logic [TO_W-1:0] cycle_cnt_q;
  logic [TO_W-1:0] cycle_inc_d;
  logic [31:0]     dp_pattern_q;
  logic [3:0]      dp_n_q;
  logic            dp_rst_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            fail_q;

  // Saturating increment so a huge timeout cannot wrap the counter.
  assign cycle_inc_d = (&cycle_cnt_q) ? cycle_cnt_q
                                      : cycle_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};

  // Run sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= 4'd0;
      timeout_q    <= {TO_W{1'b0}};
      cycle_cnt_q  <= {TO_W{1'b0}};
      dp_pattern_q <= 32'd0;
      dp_n_q       <= 4'd0;
      dp_rst_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dp_pattern_q <= cfg_pattern;
            dp_n_q       <= cfg_n;
            timeout_q    <= cfg_timeout;
            cycle_cnt_q  <= {TO_W{1'b0}};
            rst_cnt_q    <= 4'd0;
            pass_q       <= 1'b0;
            // A run that can never succeed finishes at once without touching the datapath.
            if ((cfg_n == 4'd0) || (cfg_timeout == {TO_W{1'b0}})) begin
              state_q  <= ST_DONE;
              fail_q   <= 1'b1;
              done_q   <= 1'b1;
              dp_rst_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              state_q  <= ST_RESET_DP;
              fail_q   <= 1'b0;
              dp_rst_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end else begin
            dp_rst_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_RESET_DP: begin
          if (abort) begin
            state_q  <= ST_DONE;
            fail_q   <= 1'b1;
            done_q   <= 1'b1;
            dp_rst_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_q  <= ST_RUN;
            dp_rst_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 4'd1;
          end
        end
        ST_RUN: begin
          cycle_cnt_q <= cycle_inc_d;
          // Priority: abort, then detection, then timeout.
          if (abort) begin
            state_q <= ST_DONE;
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (dp_detected) begin
            state_q <= ST_DONE;
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cycle_inc_d >= timeout_q) begin
            state_q <= ST_DONE;
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          dp_rst_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dp_rst     = dp_rst_q;
  assign dp_pattern = dp_pattern_q;
  assign dp_n       = dp_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Scenario bench for prbs_test_ctrl: expected run results are queued at start
// and matched against each done pulse; per-scenario checks run inline.
module tb_prbs_test_ctrl;

  localparam int unsigned RSTC = 2;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [15:0] cnt;
    logic [31:0] pat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, dp_detected;
  logic [31:0] cfg_pattern;
  logic [3:0]  cfg_n;
  logic [15:0] cfg_timeout;
  logic        dp_rst, busy, done, pass, fail;
  logic [31:0] dp_pattern;
  logic [3:0]  dp_n;
  logic [15:0] cycle_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  prbs_test_ctrl #(.RST_CYCLES(RSTC), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_n(cfg_n), .cfg_timeout(cfg_timeout),
    .dp_detected(dp_detected), .dp_rst(dp_rst), .dp_pattern(dp_pattern),
    .dp_n(dp_n), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .cycle_cnt(cycle_cnt)
  );

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: done=1 with no run outstanding at %0t", $time);
      end else begin
        e_mon = exp_q.pop_front();
        if ({pass, fail, cycle_cnt, dp_pattern} !== {e_mon.pass, e_mon.fail, e_mon.cnt, e_mon.pat}) begin
          errors++;
          $display("FAIL sb_result: got pass=%b fail=%b cnt=%0d pat=%h, want pass=%b fail=%b cnt=%0d pat=%h",
                   pass, fail, cycle_cnt, dp_pattern, e_mon.pass, e_mon.fail, e_mon.cnt, e_mon.pat);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] pat, input logic [3:0] n, input logic [15:0] to);
    cfg_pattern = pat;
    cfg_n       = n;
    cfg_timeout = to;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({dp_rst, dp_pattern, dp_n, busy, done, pass, fail, cycle_cnt} !== {1'b1, 32'd0, 4'd0, 4'b0000, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got dp_rst=%b pat=%h n=%0d busy=%b done=%b pass=%b fail=%b cnt=%0d, want 1/0/0/0/0/0/0/0",
               dp_rst, dp_pattern, dp_n, busy, done, pass, fail, cycle_cnt);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (dp_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_dp_rst_hold: got %b want 1 before first edge", dp_rst);
    end
    step();
    checks++;
    if (dp_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_dp_rst_release: got %b want 0", dp_rst);
    end
  endtask

  task automatic test_detect();
    logic bad = 1'b0;
    exp_q.push_back('{1'b1, 1'b0, 16'd20, 32'hA5A6A7A8});
    do_start(32'hA5A6A7A8, 4'd3, 16'd100);
    checks++;
    if ({dp_rst, busy, dp_pattern, dp_n} !== {1'b1, 1'b1, 32'hA5A6A7A8, 4'd3}) begin
      errors++;
      $display("FAIL detect_latch: got dp_rst=%b busy=%b pat=%h n=%0d, want 1 1 a5a6a7a8 3", dp_rst, busy, dp_pattern, dp_n);
    end
    cfg_pattern = 32'h0;
    cfg_n       = 4'd7;
    cfg_timeout = 16'd5;
    step();
    checks++;
    if (dp_rst !== 1'b1) begin
      errors++;
      $display("FAIL detect_dp_rst_2nd: got %b want 1", dp_rst);
    end
    step();
    checks++;
    if ({dp_rst, busy} !== 2'b01) begin
      errors++;
      $display("FAIL detect_run_entry: got dp_rst=%b busy=%b want 0 1", dp_rst, busy);
    end
    repeat (19) begin
      step();
      if (dp_pattern !== 32'hA5A6A7A8 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL detect_cfg_isolation: got pat=%h busy=%b want a5a6a7a8 1 throughout", dp_pattern, busy);
    end
    dp_detected = 1'b1;
    step();
    dp_detected = 1'b0;
    checks++;
    if ({done, pass, fail, cycle_cnt} !== {3'b110, 16'd20}) begin
      errors++;
      $display("FAIL detect_done: got done=%b pass=%b fail=%b cnt=%0d want 1 1 0 20", done, pass, fail, cycle_cnt);
    end
    step();
    checks++;
    if ({done, busy, pass} !== 3'b001) begin
      errors++;
      $display("FAIL detect_hold: got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_q.push_back('{1'b0, 1'b1, 16'd10, 32'h1111_2222});
    do_start(32'h1111_2222, 4'd3, 16'd10);
    wait_done(40, n);
    checks++;
    if (n != RSTC + 10 || pass !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles pass=%b fail=%b want %0d 0 1", n, pass, fail, RSTC + 10);
    end
    step();
  endtask

  task automatic test_tie();
    exp_q.push_back('{1'b1, 1'b0, 16'd10, 32'h3333_4444});
    do_start(32'h3333_4444, 4'd2, 16'd10);
    repeat (RSTC + 9) step();
    dp_detected = 1'b1;
    step();
    dp_detected = 1'b0;
    checks++;
    if ({done, pass, fail} !== 3'b110) begin
      errors++;
      $display("FAIL tie_priority: got done=%b pass=%b fail=%b want 1 1 0", done, pass, fail);
    end
    step();
  endtask

  task automatic test_zero_cfg();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b0, 1'b1, 16'd0, 32'h5555_0000 + 32'(k)});
      if (k == 0) do_start(32'h5555_0000, 4'd0, 16'd100);
      else        do_start(32'h5555_0001, 4'd3, 16'd0);
      checks++;
      if ({done, fail, pass, dp_rst, busy} !== 5'b11000) begin
        errors++;
        $display("FAIL zero_cfg_%0d: got done=%b fail=%b pass=%b dp_rst=%b busy=%b want 1 1 0 0 0",
                 k, done, fail, pass, dp_rst, busy);
      end
      step();
      checks++;
      if ({done, dp_rst, fail} !== 3'b001) begin
        errors++;
        $display("FAIL zero_cfg_after_%0d: got done=%b dp_rst=%b fail=%b want 0 0 1", k, done, dp_rst, fail);
      end
    end
  endtask

  task automatic test_start_in_run();
    exp_q.push_back('{1'b1, 1'b0, 16'd8, 32'hA5A6A7A8});
    do_start(32'hA5A6A7A8, 4'd3, 16'd100);
    repeat (RSTC + 3) step();
    cfg_pattern = 32'h0000_1234;
    cfg_n       = 4'd0;
    cfg_timeout = 16'd3;
    start       = 1'b1;
    step();
    start       = 1'b0;
    checks++;
    if ({cycle_cnt, busy, dp_rst, dp_pattern} !== {16'd4, 1'b1, 1'b0, 32'hA5A6A7A8}) begin
      errors++;
      $display("FAIL start_in_run: got cnt=%0d busy=%b dp_rst=%b pat=%h want 4 1 0 a5a6a7a8",
               cycle_cnt, busy, dp_rst, dp_pattern);
    end
    repeat (3) step();
    dp_detected = 1'b1;
    step();
    dp_detected = 1'b0;
    step();
  endtask

  task automatic test_abort();
    exp_q.push_back('{1'b0, 1'b1, 16'd5, 32'h6666_7777});
    do_start(32'h6666_7777, 4'd3, 16'd100);
    repeat (RSTC + 4) step();
    abort       = 1'b1;
    dp_detected = 1'b1;
    step();
    abort       = 1'b0;
    dp_detected = 1'b0;
    checks++;
    if ({done, pass, fail, cycle_cnt} !== {3'b101, 16'd5}) begin
      errors++;
      $display("FAIL abort_run: got done=%b pass=%b fail=%b cnt=%0d want 1 0 1 5", done, pass, fail, cycle_cnt);
    end
    step();
    exp_q.push_back('{1'b0, 1'b1, 16'd0, 32'h8888_9999});
    do_start(32'h8888_9999, 4'd3, 16'd100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({done, fail, dp_rst, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL abort_reset_dp: got done=%b fail=%b dp_rst=%b busy=%b want 1 1 0 0", done, fail, dp_rst, busy);
    end
    step();
  endtask

  task automatic test_rst_mid_run();
    logic seen = 1'b0;
    do_start(32'hA5A6A7A8, 4'd3, 16'd100);
    repeat (RSTC + 4) step();
    rst = 1'b1;
    #1;
    checks++;
    if ({dp_rst, dp_pattern, dp_n, busy, done, pass, fail, cycle_cnt} !== {1'b1, 32'd0, 4'd0, 4'b0000, 16'd0}) begin
      errors++;
      $display("FAIL rst_mid_run: got dp_rst=%b pat=%h n=%0d busy=%b done=%b pass=%b fail=%b cnt=%0d want reset values",
               dp_rst, dp_pattern, dp_n, busy, done, pass, fail, cycle_cnt);
    end
    step();
    rst = 1'b0;
    repeat (4) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || dp_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done/busy activity=%b dp_rst=%b want 0 0", seen, dp_rst);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{1'b1, 1'b0, 16'd3, 32'hCAFE_0001});
    do_start(32'hCAFE_0001, 4'd1, 16'd50);
    repeat (RSTC + 2) step();
    dp_detected = 1'b1;
    step();
    dp_detected = 1'b0;
    do_start(32'hCAFE_0002, 4'd1, 16'd50);
    checks++;
    if ({busy, done, dp_rst, pass} !== 4'b0001) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b dp_rst=%b pass=%b want 0 0 0 1", busy, done, dp_rst, pass);
    end
    exp_q.push_back('{1'b1, 1'b0, 16'd6, 32'hCAFE_0003});
    do_start(32'hCAFE_0003, 4'd2, 16'd50);
    repeat (RSTC + 5) step();
    dp_detected = 1'b1;
    step();
    dp_detected = 1'b0;
    checks++;
    if ({done, cycle_cnt, dp_n} !== {1'b1, 16'd6, 4'd2}) begin
      errors++;
      $display("FAIL back_to_back: got done=%b cnt=%0d n=%0d want 1 6 2", done, cycle_cnt, dp_n);
    end
    step();
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    dp_detected = 1'b0;
    cfg_pattern = 32'd0;
    cfg_n       = 4'd0;
    cfg_timeout = 16'd0;
    test_reset();
    test_detect();
    test_timeout();
    test_tie();
    test_zero_cfg();
    test_start_in_run();
    test_abort();
    test_rst_mid_run();
    test_back_to_back();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d outstanding runs want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_test_ctrl.md
PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2, number of cycles dp_rst is held high before each run (legal 1..15).
REQ-002 Parameter TO_W, default 16, width of the timeout and cycle counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a test run.
REQ-006 abort  input  1  level request to stop the current run.
REQ-007 cfg_pattern  input  32  pattern to be detected by the datapath.
REQ-008 cfg_n  input  4  number of pattern repetitions required.
REQ-009 cfg_timeout  input  TO_W  maximum RUN cycles allowed before failure.
REQ-010 dp_detected  input  1  pattern_detected flag from the PRBS datapath.
REQ-011 dp_rst  output  1  reset driven to the PRBS datapath.
REQ-012 dp_pattern  output  32  latched pattern driven to the datapath.
REQ-013 dp_n  output  4  latched repetition count driven to the datapath.
REQ-014 busy  output  1  high in RESET_DP and RUN.
REQ-015 done  output  1  one-cycle pulse when a run ends.
REQ-016 pass  output  1  result flag, held until the next accepted start.
REQ-017 fail  output  1  result flag, held until the next accepted start.
REQ-018 cycle_cnt  output  TO_W  number of RUN cycles elapsed in the last or current run.

Function
REQ-019 The FSM SHALL have the states IDLE, RESET_DP, RUN and DONE.
REQ-020 In IDLE, start SHALL latch cfg_pattern into dp_pattern, cfg_n into dp_n and cfg_timeout internally, clear pass, fail and cycle_cnt, and enter RESET_DP on the next cycle.
REQ-021 A start with cfg_n==0 or cfg_timeout==0 SHALL go directly to DONE with fail=1 and SHALL NOT toggle dp_rst.
REQ-022 start SHALL be ignored while busy=1 or while in DONE.
REQ-023 RESET_DP SHALL hold dp_rst=1 for exactly RST_CYCLES cycles and then enter RUN with dp_rst=0.
REQ-024 In RUN, cycle_cnt SHALL increment by 1 each cycle, saturating at all-ones.
REQ-025 In RUN, dp_detected=1 SHALL set pass=1 and enter DONE; cycle_cnt SHALL hold the count including that cycle.
REQ-026 In RUN, when cycle_cnt reaches the latched timeout without detection, fail SHALL be set to 1 and the FSM SHALL enter DONE.
REQ-027 When detection and timeout occur in the same cycle, pass SHALL take priority (pass=1, fail=0).
REQ-028 abort=1 in RESET_DP or RUN SHALL enter DONE with fail=1; abort SHALL take priority over detection.
REQ-029 dp_detected SHALL be ignored outside RUN.
REQ-030 DONE SHALL last one cycle, assert done=1 and return to IDLE; pass and fail SHALL never both be 1.
REQ-031 cfg_* changes after the start cycle SHALL NOT affect the run in progress.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, dp_rst=1, dp_pattern=0, dp_n=0, busy=0, done=0, pass=0, fail=0 and cycle_cnt=0.
REQ-033 After rst deasserts, dp_rst SHALL return to 0 on the first clock edge in IDLE.
REQ-034 rst asserted mid-run SHALL discard the run without producing a done pulse.

Structure
REQ-035 The FSM state encoding and the RST_CYCLES and TO_W defaults SHALL reside in the shared package prbs_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the counters and FSM SHALL be inline, and the PRBS datapath SHALL be instantiated only by the top level.

Verification
REQ-037 Config pattern=32'hA5A6A7A8, n=3, timeout=100; start; stub asserts dp_detected on RUN cycle 20 -> dp_rst high for 2 cycles, done pulse, pass=1, cycle_cnt=20.
REQ-038 Config timeout=10; dp_detected never asserted -> fail=1, cycle_cnt=10, done one cycle after the 10th RUN cycle.
REQ-039 dp_detected asserted on the cycle cycle_cnt reaches timeout=10 -> pass=1, fail=0.
REQ-040 Config n=0 -> done on the cycle after start with fail=1 and no dp_rst pulse; start during RUN -> ignored and cycle_cnt unaffected.
REQ-041 abort asserted at RUN cycle 5 -> fail=1, cycle_cnt=5; rst asserted at RUN cycle 5 -> immediate IDLE with all outputs at reset values and no done pulse.
REQ-042 cfg_pattern changed to 32'h0 one cycle after start -> dp_pattern remains 32'hA5A6A7A8 for the entire run.
